// File: rtl/map_pixel_server_pkg.sv
// Shared types and constants for the map pixel server: loader FSM states and
// the colour shown when no map is committed.
package map_pixel_server_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        PENDING = 2'd2
    } srv_state_t;

    localparam int              RGB_W           = 12;
    localparam logic [RGB_W-1:0] MAP_DEFAULT_RGB = 12'h000;

endpackage

// File: rtl/map_pixel_server_bram_sdp.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Read-during-write to the same word returns the old contents.
module map_pixel_server_bram_sdp #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/map_pixel_server.sv
// Pixel-fetch responder: fixed 2-cycle read pipeline over a double-buffered pixel RAM,
// with a valid/ready loader that commits into the back bank and swaps at frame_start.
module map_pixel_server
    import map_pixel_server_pkg::*;
#(
    parameter int               ADDR_W      = 11,
    parameter int               DEPTH       = 2048,
    parameter logic [RGB_W-1:0] DEFAULT_RGB = MAP_DEFAULT_RGB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic [RGB_W-1:0]  rgb_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    input  logic              wr_last,
    input  logic              frame_start,
    output logic              map_valid,
    output logic              swap_done,
    output logic              front_bank,
    output logic [ADDR_W:0]   beat_cnt
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] BEAT_MAX = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (v == BEAT_MAX) ? BEAT_MAX : v + 1'b1;
    endfunction

    srv_state_t        r_state;
    logic              r_wr_ready;
    logic              r_map_valid;
    logic              r_swap_done;
    logic              r_front_bank;
    logic [ADDR_W:0]   r_beat_cnt;

    logic              w_accept;
    logic              w_wr_en;
    logic              w_we0;
    logic              w_we1;

    logic [ADDR_W-1:0] r_addr_p0;
    logic              r_bank_p0;
    logic              r_vld_p0;
    logic              r_bank_p1;
    logic              r_vld_p1;
    logic [RGB_W-1:0]  w_rd0_p1;
    logic [RGB_W-1:0]  w_rd1_p1;

    assign w_accept = wr_valid && r_wr_ready;
    assign w_wr_en  = w_accept && ({1'b0, wr_addr} < DEPTH_L);
    // Only the back bank (the one not being served) may be written.
    assign w_we0    = w_wr_en && r_front_bank;
    assign w_we1    = w_wr_en && !r_front_bank;

    // Loader FSM; a commit never swaps in the cycle it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ready   <= 1'b1;
            r_map_valid  <= 1'b0;
            r_swap_done  <= 1'b0;
            r_front_bank <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                IDLE, LOADING: begin
                    if (w_accept) begin
                        r_beat_cnt <= (r_state == IDLE) ? (ADDR_W+1)'(1) : sat_inc(r_beat_cnt);
                        if (wr_last) begin
                            r_state    <= PENDING;
                            r_wr_ready <= 1'b0;
                        end else begin
                            r_state <= LOADING;
                        end
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        r_front_bank <= ~r_front_bank;
                        r_map_valid  <= 1'b1;
                        r_swap_done  <= 1'b1;
                        r_beat_cnt   <= '0;
                        r_state      <= IDLE;
                        r_wr_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage p0: capture address with the bank and validity it was issued against
    always_ff @(posedge clk) begin
        r_addr_p0 <= pixel_addr;
        r_bank_p0 <= r_front_bank;
        r_bank_p1 <= r_bank_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= r_map_valid && ({1'b0, pixel_addr} < DEPTH_L);
            r_vld_p1 <= r_vld_p0;
        end
    end

    // Stage p1: synchronous RAM read of both banks
    map_pixel_server_bram_sdp #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (RGB_W)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_addr_p0),
        .o_rdata (w_rd0_p1)
    );

    map_pixel_server_bram_sdp #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (RGB_W)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_addr_p0),
        .o_rdata (w_rd1_p1)
    );

    // Stage p2: select the bank captured with the address, mask to default
    assign rgb_pixel  = r_vld_p1 ? (r_bank_p1 ? w_rd1_p1 : w_rd0_p1) : DEFAULT_RGB;

    assign wr_ready   = r_wr_ready;
    assign map_valid  = r_map_valid;
    assign swap_done  = r_swap_done;
    assign front_bank = r_front_bank;
    assign beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_map_pixel_server.sv
// Directed bench for map_pixel_server: a per-cycle read scoreboard against a bank model,
// plus explicit checks of the loader handshake, commit/swap timing and reset.
module tb_map_pixel_server;

    logic        clk;
    logic        rst;
    logic [10:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_last;
    logic        frame_start;
    logic        map_valid;
    logic        swap_done;
    logic        front_bank;
    logic [11:0] beat_cnt;

    map_pixel_server dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_addr  (pixel_addr),
        .rgb_pixel   (rgb_pixel),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .frame_start (frame_start),
        .map_valid   (map_valid),
        .swap_done   (swap_done),
        .front_bank  (front_bank),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [11:0] q [$];
    logic [11:0] m_bank [2][2048];
    int          m_front = 0;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input logic [10:0] a);
        if (!m_valid) return 12'h000;
        return m_bank[m_front][int'(a)];
    endfunction

    // One clock: record what the current address must return, advance, and compare
    // the result of the address issued two cycles earlier.
    task automatic clk1(input bit do_swap);
        logic [11:0] e;
        q.push_back(exp_rgb(pixel_addr));
        @(posedge clk);
        #1;
        if (do_swap) begin
            m_front = 1 - m_front;
            m_valid = 1'b1;
        end
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("rgb", 32'(rgb_pixel), 32'(e));
        end
    endtask

    task automatic beat(input int a, input logic [11:0] d, input bit last, input bit fs);
        wr_valid    = 1'b1;
        wr_addr     = 11'(a);
        wr_data     = d;
        wr_last     = last;
        frame_start = fs;
        m_bank[1 - m_front][a] = d;
        clk1(1'b0);
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pixel_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; wr_last = 1'b0; frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb_pixel), 32'h000);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_map_valid", 32'(map_valid), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        chk("rst_front_bank", 32'(front_bank), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0;

        // no map committed: everything reads as default
        for (int a = 0; a < 16; a++) begin
            pixel_addr = 11'(a);
            clk1(1'b0);
            chk("sweep_map_valid", 32'(map_valid), 32'd0);
        end

        // full load of bank 1 with addr -> addr
        for (int i = 0; i < 2048; i++) begin
            beat(i, 12'(i), i == 2047, 1'b0);
            if (i == 0 || i == 1000) chk("load_beat_cnt", 32'(beat_cnt), 32'(i + 1));
        end
        chk("pend_beat_cnt", 32'(beat_cnt), 32'd2048);
        chk("pend_wr_ready", 32'(wr_ready), 32'd0);
        chk("pend_front", 32'(front_bank), 32'd0);

        // beats offered while pending are refused and never written
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 12'hFFF;
            clk1(1'b0);
            chk("hold_wr_ready", 32'(wr_ready), 32'd0);
            chk("hold_beat_cnt", 32'(beat_cnt), 32'd2048);
        end
        wr_valid = 1'b0;

        frame_start = 1'b1;
        clk1(1'b1);
        frame_start = 1'b0;
        chk("swap1_done", 32'(swap_done), 32'd1);
        chk("swap1_front", 32'(front_bank), 32'd1);
        chk("swap1_map_valid", 32'(map_valid), 32'd1);
        chk("swap1_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("swap1_wr_ready", 32'(wr_ready), 32'd1);
        clk1(1'b0);
        chk("swap1_done_once", 32'(swap_done), 32'd0);

        pixel_addr = 11'd5;
        clk1(1'b0);
        pixel_addr = 11'd2047;
        clk1(1'b0);
        chk("latency2", 32'(rgb_pixel), 32'h005);
        pixel_addr = 11'd1024;
        clk1(1'b0);
        pixel_addr = 11'd0;
        clk1(1'b0);
        clk1(1'b0);

        // frame_start in IDLE is ignored
        frame_start = 1'b1;
        clk1(1'b0);
        frame_start = 1'b0;
        chk("idle_fs_front", 32'(front_bank), 32'd1);
        chk("idle_fs_done", 32'(swap_done), 32'd0);

        // load bank 0 with AAA; gap cycles, a frame_start mid-load, last beat with frame_start
        for (int i = 0; i < 16; i++) begin
            beat(i, 12'hAAA, i == 15, i == 3 || i == 15);
            if (i == 7) begin
                clk1(1'b0);
                clk1(1'b0);
                chk("gap_beat_cnt", 32'(beat_cnt), 32'd8);
            end
        end
        chk("same_cycle_front", 32'(front_bank), 32'd1);
        chk("same_cycle_wr_ready", 32'(wr_ready), 32'd0);
        clk1(1'b0);
        chk("same_cycle_no_done", 32'(swap_done), 32'd0);
        chk("same_cycle_beat_cnt", 32'(beat_cnt), 32'd16);
        frame_start = 1'b1;
        clk1(1'b1);
        frame_start = 1'b0;
        chk("swap2_front", 32'(front_bank), 32'd0);
        chk("swap2_done", 32'(swap_done), 32'd1);

        // stream reads across a swap from AAA to 555
        for (int i = 0; i < 16; i++) beat(i, 12'h555, i == 15, 1'b0);
        for (int i = 0; i < 40; i++) begin
            pixel_addr  = 11'(i % 16);
            frame_start = (i == 20);
            clk1(i == 20);
            frame_start = 1'b0;
        end
        chk("swap3_front", 32'(front_bank), 32'd1);

        // beat counter saturates at 2**ADDR_W
        for (int i = 0; i < 2050; i++) begin
            beat(i % 2048, 12'h0F0, i == 2049, 1'b0);
            if (i == 2047 || i == 2048) chk("sat_beat_cnt", 32'(beat_cnt), 32'd2048);
        end
        chk("sat_final_cnt", 32'(beat_cnt), 32'd2048);
        frame_start = 1'b1;
        clk1(1'b1);
        frame_start = 1'b0;
        pixel_addr = 11'd100;
        clk1(1'b0);
        pixel_addr = 11'd2047;
        clk1(1'b0);
        clk1(1'b0);
        clk1(1'b0);

        // reset in the middle of a load
        for (int i = 0; i < 100; i++) beat(i, 12'h123, 1'b0, 1'b0);
        chk("midload_beat_cnt", 32'(beat_cnt), 32'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        m_front = 0;
        m_valid = 1'b0;
        rst = 1'b0;
        chk("rst2_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst2_front", 32'(front_bank), 32'd0);
        chk("rst2_map_valid", 32'(map_valid), 32'd0);
        chk("rst2_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst2_rgb", 32'(rgb_pixel), 32'h000);
        for (int a = 0; a < 8; a++) begin
            pixel_addr = 11'(a * 200);
            clk1(1'b0);
        end
        beat(7, 12'h777, 1'b0, 1'b0);
        chk("rst2_idle_beat", 32'(beat_cnt), 32'd1);
        clk1(1'b0);
        clk1(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
